// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus interconnect: error codes,
// read FSM states and the default SoC peripheral base addresses.
package dbus_pkg;

   // Error codes reported on err_code
   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_RD_UNMAP   = 2'b01;
   localparam logic [1:0] ERR_WR_UNMAP   = 2'b10;
   localparam logic [1:0] ERR_RD_TIMEOUT = 2'b11;

   // Read channel FSM: WAIT covers every cycle in which a response is owed
   typedef enum logic {IDLE, WAIT} rd_state_e;

   // Default SoC map, upper address byte of each peripheral
   localparam logic [7:0] BASE_IRAM    = 8'h00;
   localparam logic [7:0] BASE_DRAM    = 8'h01;
   localparam logic [7:0] BASE_UART    = 8'h02;
   localparam logic [7:0] BASE_SEG     = 8'h03;
   localparam logic [7:0] BASE_SEC_CLK = 8'h04;
   localparam logic [7:0] BASE_BUTTON  = 8'h05;
   localparam logic [7:0] BASE_BUZZER  = 8'h06;

endpackage

// File: rtl/dbus_addr_decode.sv
// Priority address decoder: compares the upper address bits against a packed
// base table and returns a one-hot select (lowest index wins) and a hit flag.
module dbus_addr_decode
   import dbus_pkg::*;
#(
   parameter int                                 NSLAVE         = 8,
   parameter int                                 BASEADDR_WIDTH = 8,
   parameter logic [NSLAVE*BASEADDR_WIDTH-1:0]   BASEADDRS      = '0
) (
   input  logic [31:0]       addr_i,
   output logic [NSLAVE-1:0] sel_o,
   output logic              hit_o
);

   // Scan from the highest index down so the lowest matching index is kept
   always_comb begin
      sel_o = '0;
      hit_o = 1'b0;
      for (int i = NSLAVE-1; i >= 0; i--) begin
         if (addr_i[31 -: BASEADDR_WIDTH] == BASEADDRS[i*BASEADDR_WIDTH +: BASEADDR_WIDTH]) begin
            sel_o    = '0;
            sel_o[i] = 1'b1;
            hit_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect between the CPU data port and NSLAVE peripherals.
// Writes are decoded combinationally; reads go through a two-state FSM that
// supports slave wait-states, a timeout, and a sticky first-error capture.
module dbus_interconnect
   import dbus_pkg::*;
#(
   parameter int                                 NSLAVE         = 8,
   parameter int                                 BASEADDR_WIDTH = 8,
   parameter int                                 SLAVE_ADDRW    = 14,
   parameter logic [NSLAVE*BASEADDR_WIDTH-1:0]   BASEADDRS      = '0,
   parameter int                                 TIMEOUT        = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m_rd,
   input  logic [31:0]            m_raddr,
   output logic [31:0]            m_rdata,
   output logic                   m_stall,
   input  logic                   m_wr,
   input  logic [31:0]            m_waddr,
   input  logic [31:0]            m_wdata,
   input  logic [3:0]             m_wstrb,
   output logic [NSLAVE-1:0]      s_rd,
   output logic [SLAVE_ADDRW-1:0] s_raddr,
   input  logic [NSLAVE*32-1:0]   s_rdata,
   input  logic [NSLAVE-1:0]      s_rvalid,
   output logic [NSLAVE-1:0]      s_wr,
   output logic [SLAVE_ADDRW-1:0] s_waddr,
   output logic [31:0]            s_wdata,
   output logic [3:0]             s_wstrb,
   output logic                   err_valid,
   output logic [31:0]            err_addr,
   output logic [1:0]             err_code,
   input  logic                   err_clr
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   logic [NSLAVE-1:0] rd_sel, wr_sel;
   logic              rd_hit, wr_hit;

   // rsel is held one-hot so the response mux is a plain AND-OR
   rd_state_e         state_q, state_d;
   logic [NSLAVE-1:0] rsel_q, rsel_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       raddr_q, raddr_d;

   logic              err_valid_q, err_valid_d;
   logic [31:0]       err_addr_q, err_addr_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              rvalid_sel, resp_ok, timeout, stall_int, rd_accept;
   logic [31:0]       rdata_sel;
   logic              err_ev;
   logic [1:0]        err_ev_code;
   logic [31:0]       err_ev_addr;

   dbus_addr_decode #(
      .NSLAVE(NSLAVE), .BASEADDR_WIDTH(BASEADDR_WIDTH), .BASEADDRS(BASEADDRS)
   ) u_rd_dec (.addr_i(m_raddr), .sel_o(rd_sel), .hit_o(rd_hit));

   dbus_addr_decode #(
      .NSLAVE(NSLAVE), .BASEADDR_WIDTH(BASEADDR_WIDTH), .BASEADDRS(BASEADDRS)
   ) u_wr_dec (.addr_i(m_waddr), .sel_o(wr_sel), .hit_o(wr_hit));

   // Select the pending slave's valid and data
   always_comb begin
      rvalid_sel = |(s_rvalid & rsel_q);
      rdata_sel  = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (rsel_q[i]) rdata_sel = rdata_sel | s_rdata[i*32 +: 32];
      end
   end

   // A pending read either completes, times out after TIMEOUT stall cycles, or stalls
   always_comb begin
      resp_ok   = (state_q == WAIT) && rvalid_sel;
      timeout   = (state_q == WAIT) && !rvalid_sel && (cnt_q == TO_CNT);
      stall_int = (state_q == WAIT) && !resp_ok && !timeout;
      rd_accept = m_rd && !stall_int && !rst;
      m_stall   = stall_int && !rst;
      m_rdata   = (resp_ok && !rst) ? rdata_sel : 32'h0;
      s_rd      = rd_accept ? rd_sel : '0;
      s_wr      = (m_wr && !rst) ? wr_sel : '0;
   end

   assign s_raddr = m_raddr[SLAVE_ADDRW-1:0];
   assign s_waddr = m_waddr[SLAVE_ADDRW-1:0];
   assign s_wdata = m_wdata;
   assign s_wstrb = m_wstrb;

   // Read FSM next state; a new read may be accepted in the cycle a response completes
   always_comb begin
      state_d = state_q;
      rsel_d  = rsel_q;
      cnt_d   = cnt_q;
      raddr_d = raddr_q;
      if (stall_int) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         state_d = IDLE;
         if (rd_accept && rd_hit) begin
            state_d = WAIT;
            rsel_d  = rd_sel;
            cnt_d   = '0;
            raddr_d = m_raddr;
         end
      end
   end

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rsel_q  <= '0;
         cnt_q   <= '0;
         raddr_q <= '0;
      end else begin
         state_q <= state_d;
         rsel_q  <= rsel_d;
         cnt_q   <= cnt_d;
         raddr_q <= raddr_d;
      end
   end

   // Error event and capture; read errors beat write errors, clear yields to a new error
   always_comb begin
      err_ev      = 1'b0;
      err_ev_code = ERR_NONE;
      err_ev_addr = '0;
      if (timeout) begin
         err_ev = 1'b1; err_ev_code = ERR_RD_TIMEOUT; err_ev_addr = raddr_q;
      end else if (rd_accept && !rd_hit) begin
         err_ev = 1'b1; err_ev_code = ERR_RD_UNMAP;   err_ev_addr = m_raddr;
      end else if (m_wr && !wr_hit) begin
         err_ev = 1'b1; err_ev_code = ERR_WR_UNMAP;   err_ev_addr = m_waddr;
      end
      err_valid_d = err_valid_q;
      err_addr_d  = err_addr_q;
      err_code_d  = err_code_q;
      if (err_ev && (!err_valid_q || err_clr)) begin
         err_valid_d = 1'b1;
         err_addr_d  = err_ev_addr;
         err_code_d  = err_ev_code;
      end else if (err_clr) begin
         err_valid_d = 1'b0;
         err_addr_d  = '0;
         err_code_d  = ERR_NONE;
      end
   end

   // Error capture registers
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         err_code_q  <= ERR_NONE;
      end else begin
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
         err_code_q  <= err_code_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
   assign err_code  = err_code_q;

   // The CPU must not issue a read while stalled; such a request is dropped
   a_no_rd_while_stall: assert property (@(posedge clk) disable iff (rst) !(m_rd && m_stall));

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: a vector table for single-transaction
// decode/response behaviour plus hand sequences for multi-cycle cases.
module tb_dbus_interconnect;

   logic         clk = 1'b0;
   logic         rst;
   logic         m_rd, m_wr, err_clr;
   logic [31:0]  m_raddr, m_waddr, m_wdata;
   logic [3:0]   m_wstrb;
   logic [31:0]  m_rdata, err_addr;
   logic         m_stall, err_valid;
   logic [1:0]   err_code;
   logic [7:0]   s_rd, s_wr, s_rvalid;
   logic [13:0]  s_raddr, s_waddr;
   logic [255:0] s_rdata;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic [31:0]  rdat [8];

   int nchk = 0;
   int nerr = 0;

   // Slave 7 duplicates base 0x02 so the priority rule is exercised
   dbus_interconnect #(
      .NSLAVE(8), .BASEADDR_WIDTH(8), .SLAVE_ADDRW(14), .TIMEOUT(4),
      .BASEADDRS({8'h02, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00})
   ) dut (
      .clk(clk), .rst(rst),
      .m_rd(m_rd), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_stall(m_stall),
      .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .s_rd(s_rd), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
      .s_wr(s_wr), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .err_valid(err_valid), .err_addr(err_addr), .err_code(err_code), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always_comb begin
      s_rdata = '0;
      for (int i = 0; i < 8; i++) s_rdata[i*32 +: 32] = rdat[i];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      m_rd = 1'b0; m_wr = 1'b0; err_clr = 1'b0;
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_wstrb = '0;
   endtask

   // Inputs change at the falling edge; checks run 1 ns later
   task automatic cyc();
      @(negedge clk);
      idle();
      #1;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] waddr;
      logic [3:0]  wstrb;
      logic        rd;
      logic [31:0] raddr;
      logic [31:0] exp_swr;
      logic [31:0] exp_srd;
      logic [31:0] exp_sraddr;
      logic [31:0] exp_swaddr;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0000, 4'h0, 1'b1, 32'h0200_0010, 32'h00, 32'h04, 32'h0010, 32'h0000, 32'hA5A5_0001};
      vecs[1] = '{1'b1, 32'h0100_0020, 4'h3, 1'b1, 32'h0000_0040, 32'h02, 32'h01, 32'h0040, 32'h0020, 32'hC0DE_0000};
      vecs[2] = '{1'b1, 32'h0600_0000, 4'hF, 1'b0, 32'h0000_0000, 32'h40, 32'h00, 32'h0000, 32'h0000, 32'h0000_0000};
      vecs[3] = '{1'b0, 32'h0000_0000, 4'h0, 1'b1, 32'h06FF_FFFC, 32'h00, 32'h40, 32'h3FFC, 32'h0000, 32'hC0DE_0006};
      vecs[4] = '{1'b1, 32'h0403_4567, 4'h8, 1'b1, 32'h0500_3FFC, 32'h10, 32'h20, 32'h3FFC, 32'h0567, 32'hC0DE_0005};
      vecs[5] = '{1'b1, 32'h0200_0004, 4'h5, 1'b1, 32'h0200_0008, 32'h04, 32'h04, 32'h0008, 32'h0004, 32'hA5A5_0001};
      vecs[6] = '{1'b1, 32'h0500_0200, 4'h2, 1'b1, 32'h0300_0100, 32'h20, 32'h08, 32'h0100, 32'h0200, 32'hC0DE_0003};

      for (int i = 0; i < 8; i++) rdat[i] = 32'hC0DE_0000 | 32'(i);
      rdat[2]  = 32'hA5A5_0001;
      s_rvalid = 8'hFF;
      idle();
      rst = 1'b1;

      // Reset: enables gated while rst is high
      @(negedge clk);
      m_wr = 1'b1; m_waddr = 32'h0100_0000; m_rd = 1'b1; m_raddr = 32'h0000_0000;
      #1;
      chk("rst_s_wr_gated", 32'(s_wr), 32'h0);
      chk("rst_s_rd_gated", 32'(s_rd), 32'h0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_m_stall", 32'(m_stall), 32'h0);
      chk("rst_m_rdata", m_rdata, 32'h0);
      chk("rst_err_valid", 32'(err_valid), 32'h0);
      chk("rst_err_code", 32'(err_code), 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);

      // Table: issue cycle then response cycle
      for (int v = 0; v < 7; v++) begin
         @(negedge clk);
         idle();
         m_wr = vecs[v].wr; m_waddr = vecs[v].waddr; m_wstrb = vecs[v].wstrb;
         m_wdata = 32'hDA7A_0000 | 32'(v);
         m_rd = vecs[v].rd; m_raddr = vecs[v].raddr;
         #1;
         chk($sformatf("v%0d_s_wr", v), 32'(s_wr), vecs[v].exp_swr);
         chk($sformatf("v%0d_s_rd", v), 32'(s_rd), vecs[v].exp_srd);
         chk($sformatf("v%0d_s_raddr", v), 32'(s_raddr), vecs[v].exp_sraddr);
         chk($sformatf("v%0d_s_waddr", v), 32'(s_waddr), vecs[v].exp_swaddr);
         chk($sformatf("v%0d_s_wdata", v), s_wdata, 32'hDA7A_0000 | 32'(v));
         chk($sformatf("v%0d_s_wstrb", v), 32'(s_wstrb), 32'(vecs[v].wstrb));
         cyc();
         chk($sformatf("v%0d_m_rdata", v), m_rdata, vecs[v].exp_rdata);
         chk($sformatf("v%0d_m_stall", v), 32'(m_stall), 32'h0);
         chk($sformatf("v%0d_err_valid", v), 32'(err_valid), 32'h0);
      end

      // Wait-states: slave 1 valid after three stall cycles
      s_rvalid[1] = 1'b0;
      @(negedge clk);
      idle(); m_rd = 1'b1; m_raddr = 32'h0100_0000;
      #1;
      chk("ws_s_rd", 32'(s_rd), 32'h02);
      for (int c = 0; c < 3; c++) begin
         cyc();
         chk($sformatf("ws_stall_c%0d", c), 32'(m_stall), 32'h1);
         chk($sformatf("ws_rdata_c%0d", c), m_rdata, 32'h0);
      end
      @(negedge clk);
      idle(); s_rvalid[1] = 1'b1; rdat[1] = 32'h1234_5678;
      #1;
      chk("ws_stall_drop", 32'(m_stall), 32'h0);
      chk("ws_rdata", m_rdata, 32'h1234_5678);
      cyc();
      chk("ws_rdata_after", m_rdata, 32'h0);
      rdat[1] = 32'hC0DE_0001;

      // Timeout: slave 3 never valid
      s_rvalid[3] = 1'b0;
      @(negedge clk);
      idle(); m_rd = 1'b1; m_raddr = 32'h0300_0004;
      #1;
      chk("to_s_rd", 32'(s_rd), 32'h08);
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk($sformatf("to_stall_c%0d", c), 32'(m_stall), 32'h1);
      end
      cyc();
      chk("to_stall_drop", 32'(m_stall), 32'h0);
      chk("to_rdata", m_rdata, 32'h0);
      chk("to_err_pending", 32'(err_valid), 32'h0);
      cyc();
      chk("to_err_valid", 32'(err_valid), 32'h1);
      chk("to_err_code", 32'(err_code), 32'h3);
      chk("to_err_addr", err_addr, 32'h0300_0004);
      err_clr = 1'b1;
      cyc();
      chk("to_err_cleared", 32'(err_valid), 32'h0);
      s_rvalid[3] = 1'b1;

      // Unmapped write, sticky capture, clear together with new error
      @(negedge clk);
      idle(); m_wr = 1'b1; m_waddr = 32'h0F00_0000; m_wstrb = 4'hF;
      #1;
      chk("uw_s_wr", 32'(s_wr), 32'h0);
      cyc();
      chk("uw_err_valid", 32'(err_valid), 32'h1);
      chk("uw_err_code", 32'(err_code), 32'h2);
      chk("uw_err_addr", err_addr, 32'h0F00_0000);
      m_rd = 1'b1; m_raddr = 32'h0D00_0000;
      #1;
      chk("ur_s_rd", 32'(s_rd), 32'h0);
      cyc();
      chk("ur_m_rdata", m_rdata, 32'h0);
      chk("ur_m_stall", 32'(m_stall), 32'h0);
      chk("ur_sticky_code", 32'(err_code), 32'h2);
      chk("ur_sticky_addr", err_addr, 32'h0F00_0000);
      err_clr = 1'b1; m_rd = 1'b1; m_raddr = 32'h0E00_0008;
      cyc();
      chk("clr_new_valid", 32'(err_valid), 32'h1);
      chk("clr_new_code", 32'(err_code), 32'h1);
      chk("clr_new_addr", err_addr, 32'h0E00_0008);
      err_clr = 1'b1;
      cyc();
      chk("clr_valid", 32'(err_valid), 32'h0);
      // Simultaneous unmapped read and write: read error wins
      m_wr = 1'b1; m_waddr = 32'h0F00_0004; m_rd = 1'b1; m_raddr = 32'h0D00_0000;
      cyc();
      chk("prio_err_code", 32'(err_code), 32'h1);
      chk("prio_err_addr", err_addr, 32'h0D00_0000);
      err_clr = 1'b1;
      cyc();
      chk("prio_clr_valid", 32'(err_valid), 32'h0);

      // Reset during WAIT aborts the read without a response or error
      s_rvalid[1] = 1'b0;
      @(negedge clk);
      idle(); m_rd = 1'b1; m_raddr = 32'h0100_0000;
      cyc();
      chk("rw_stall", 32'(m_stall), 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rw_stall_after", 32'(m_stall), 32'h0);
      chk("rw_rdata_after", m_rdata, 32'h0);
      chk("rw_err_valid", 32'(err_valid), 32'h0);
      for (int c = 0; c < 6; c++) cyc();
      chk("rw_no_late_err", 32'(err_valid), 32'h0);
      chk("rw_no_late_stall", 32'(m_stall), 32'h0);
      s_rvalid[1] = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
